// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver fed from a shadowed BCD counter chain.
// Latency: an/seg/dp are registered, one cycle behind idx/shadow; a latch shows 2 cycles later.
// Backpressure: none; en=0 blanks the display and freezes the scanner, latch is always accepted.
// Optional build macro LEADING_ZERO_BLANK_EN: blank digits above the most significant nonzero digit.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  latch,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  scan_tick,
    output logic                  frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Polarity of the "off" level on each pin group.
    localparam logic              SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic              AN_POL  = (AN_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_POL}};
    localparam logic [6:0]        SEG_OFF = {7{SEG_POL}};

    logic [DIV_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*DIGITS-1:0]   r_shadow_bcd;
    logic [DIGITS-1:0]     r_shadow_dp;
    logic [DIGITS-1:0]     r_an;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic                  r_scan_tick;
    logic                  r_frame_done;

    logic [3:0]            w_digit;
    logic                  w_dp_sel;
    logic [DIGITS-1:0]     w_an_hi;
    logic                  w_blank;
    logic [6:0]            w_seg_hi;
    logic [6:0]            w_seg_lit;

    // Shadow capture: the decoder only ever looks at these, so a frame never mixes two counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_bcd <= '0;
            r_shadow_dp  <= '0;
        end else if (latch) begin
            r_shadow_bcd <= bcd_in;
            r_shadow_dp  <= dp_in;
        end
    end

    // Prescaler and digit index; both freeze while en is low and resume where they stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_scan_tick  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (!en) begin
            r_scan_tick  <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (r_div_cnt == DIV_LAST) begin
            r_div_cnt    <= '0;
            r_idx        <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            r_scan_tick  <= 1'b1;
            r_frame_done <= (r_idx == IDX_LAST);
        end else begin
            r_div_cnt    <= r_div_cnt + DIV_W'(1);
            r_scan_tick  <= 1'b0;
            r_frame_done <= 1'b0;
        end
    end

    // Select the shadow digit, its decimal point and the anode for the current index.
    always_comb begin
        w_digit  = 4'd0;
        w_dp_sel = 1'b0;
        w_an_hi  = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit    = r_shadow_bcd[4*k +: 4];
                w_dp_sel   = r_shadow_dp[k];
                w_an_hi[k] = 1'b1;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Blank when this digit and every digit above it are zero; digit 0 always shows.
    always_comb begin
        w_blank = (r_idx != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if ((IDX_W'(k) >= r_idx) && (r_shadow_bcd[4*k +: 4] != 4'd0)) begin
                w_blank = 1'b0;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // BCD to active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    always_comb begin
        case (w_digit)
            4'd0:    w_seg_hi = 7'h3F;
            4'd1:    w_seg_hi = 7'h06;
            4'd2:    w_seg_hi = 7'h5B;
            4'd3:    w_seg_hi = 7'h4F;
            4'd4:    w_seg_hi = 7'h66;
            4'd5:    w_seg_hi = 7'h6D;
            4'd6:    w_seg_hi = 7'h7D;
            4'd7:    w_seg_hi = 7'h07;
            4'd8:    w_seg_hi = 7'h7F;
            4'd9:    w_seg_hi = 7'h6F;
            default: w_seg_hi = 7'h40;
        endcase
        w_seg_lit = w_blank ? 7'h00 : w_seg_hi;
    end

    // Registered pin drivers with board polarity applied; en low forces everything dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= SEG_POL;
        end else if (!en) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_OFF;
            r_dp  <= SEG_POL;
        end else begin
            r_an  <= AN_POL  ? ~w_an_hi   : w_an_hi;
            r_seg <= SEG_POL ? ~w_seg_lit : w_seg_lit;
            r_dp  <= SEG_POL ? ~w_dp_sel  : w_dp_sel;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign scan_tick  = r_scan_tick;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with DIGITS=4, SCAN_DIV=4, active-low segments and anodes.
// Reference: expected display derived from the count of enabled cycles since reset.
module tb_seg7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        latch;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        scan_tick;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    // Reference state: enabled clock edges since reset, plus the captured values.
    int          m_cyc;
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dpv;
        int          dig;
        logic [6:0]  eseg;
        logic        edp;
    } vec_t;

    vec_t vt[16];

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .latch(latch),
        .bcd_in(bcd_in), .dp_in(dp_in),
        .an(an), .seg(seg), .dp(dp), .scan_tick(scan_tick), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_hi(input logic [3:0] v);
        case (v)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Pin level for digit k of a captured value, including optional leading-zero blanking.
    function automatic logic [6:0] exp_seg(input logic [15:0] b, input int k);
        int msnz = 0;
        for (int i = 0; i < DIGITS; i++)
            if (b[4*i +: 4] != 4'd0) msnz = i;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > msnz) return 7'h7F;
`else
        if (msnz > DIGITS) return 7'h7F;
`endif
        return ~seg_hi(b[4*k +: 4]);
    endfunction

    // One clock edge: predict, clock, compare all outputs, advance the reference.
    task automatic step();
        logic [13:0] e;
        logic [15:0] nb;
        logic [3:0]  nd;
        logic        ven;
        logic        vlat;
        int          idx;
        ven  = en;
        vlat = latch;
        nb   = bcd_in;
        nd   = dp_in;
        if (ven) begin
            idx = (m_cyc / SCAN_DIV) % DIGITS;
            e = {~(4'b0001 << idx), exp_seg(m_bcd, idx), ~m_dp[idx],
                 (m_cyc % SCAN_DIV) == SCAN_DIV - 1, (m_cyc % FRAME) == FRAME - 1};
        end else begin
            e = {4'hF, 7'h7F, 1'b1, 2'b00};
        end
        @(posedge clk);
        #1;
        chk("outputs", {18'd0, an, seg, dp, scan_tick, frame_done}, {18'd0, e});
        if (ven) m_cyc++;
        if (vlat) begin
            m_bcd = nb;
            m_dp  = nd;
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_bcd = '0;
        m_dp  = '0;
    endtask

    initial begin
        logic [6:0] new_tab [4];
        logic [3:0] sel;
        logic [3:0] a0;
        logic       found;
        logic       want_e;
        int         nticks;
        int         nfd;
        int         cnt;
        int         nd;

        // Active-low expected patterns, hand-derived from the decode table.
        vt[0]  = '{16'h9876, 4'b0000, 0, 7'h02, 1'b1};
        vt[1]  = '{16'h9876, 4'b0000, 1, 7'h78, 1'b1};
        vt[2]  = '{16'h9876, 4'b0000, 2, 7'h00, 1'b1};
        vt[3]  = '{16'h9876, 4'b0000, 3, 7'h10, 1'b1};
        vt[4]  = '{16'hFA00, 4'b0101, 0, 7'h40, 1'b0};
        vt[5]  = '{16'hFA00, 4'b0101, 1, 7'h40, 1'b1};
        vt[6]  = '{16'hFA00, 4'b0101, 2, 7'h3F, 1'b0};
        vt[7]  = '{16'hFA00, 4'b0101, 3, 7'h3F, 1'b1};
        vt[8]  = '{16'h0050, 4'b1000, 0, 7'h40, 1'b1};
        vt[9]  = '{16'h0050, 4'b1000, 1, 7'h12, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
        vt[10] = '{16'h0050, 4'b1000, 2, 7'h7F, 1'b1};
        vt[11] = '{16'h0050, 4'b1000, 3, 7'h7F, 1'b0};
`else
        vt[10] = '{16'h0050, 4'b1000, 2, 7'h40, 1'b1};
        vt[11] = '{16'h0050, 4'b1000, 3, 7'h40, 1'b0};
`endif
        vt[12] = '{16'h4321, 4'b0000, 0, 7'h79, 1'b1};
        vt[13] = '{16'h4321, 4'b0000, 1, 7'h24, 1'b1};
        vt[14] = '{16'h4321, 4'b0000, 2, 7'h30, 1'b1};
        vt[15] = '{16'h4321, 4'b0000, 3, 7'h19, 1'b1};
        new_tab = '{7'h79, 7'h24, 7'h30, 7'h19};

        rst_n  = 1'b0;
        en     = 1'b0;
        latch  = 1'b0;
        bcd_in = '0;
        dp_in  = '0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {18'd0, an, seg, dp, scan_tick, frame_done}, {18'd0, 4'hF, 7'h7F, 1'b1, 2'b00});
        rst_n = 1'b1;
        en    = 1'b1;

        // Scan timing over two frames.
        nticks = 0;
        nfd    = 0;
        want_e = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (want_e) chk("frame_next_an", {28'd0, an}, 32'hE);
            want_e = 1'b0;
            if (scan_tick) nticks++;
            if (frame_done) begin
                nfd++;
                chk("frame_an", {28'd0, an}, 32'h7);
                want_e = 1'b1;
            end
        end
        chk("tick_count", nticks, 8);
        chk("frame_count", nfd, 2);

        // Asynchronous reset mid-scan, then restart from digit 0.
        bcd_in = 16'h1234;
        latch  = 1'b1;
        step();
        latch  = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #2;
        chk("reset_async", {18'd0, an, seg, dp, scan_tick, frame_done}, {18'd0, 4'hF, 7'h7F, 1'b1, 2'b00});
        #2;
        rst_n = 1'b1;
        model_reset();
        step();
        chk("first_digit", {28'd0, an}, 32'hE);

        // Decode sweep.
        for (int i = 0; i < 16; i++) begin
            bcd_in = vt[i].bcd;
            dp_in  = vt[i].dpv;
            latch  = 1'b1;
            step();
            latch  = 1'b0;
            step();
            sel   = ~(4'b0001 << vt[i].dig);
            found = (an == sel);
            for (int c = 0; c < 20 && !found; c++) begin
                step();
                found = (an == sel);
            end
            chk("vec_found", {31'd0, found}, 32'd1);
            chk("vec_seg", {25'd0, seg}, {25'd0, vt[i].eseg});
            chk("vec_dp", {31'd0, dp}, {31'd0, vt[i].edp});
        end

        // Inputs churn without a latch: display must follow only the shadow.
        for (int i = 0; i < 8; i++) begin
            bcd_in = 16'($urandom());
            dp_in  = 4'($urandom_range(0, 15));
            step();
        end

        // Latch on the same edge as the index advance.
        for (int c = 0; c < 8 && (m_cyc % SCAN_DIV) != SCAN_DIV - 1; c++) step();
        bcd_in = 16'h4321;
        dp_in  = 4'b0000;
        latch  = 1'b1;
        step();
        latch  = 1'b0;
        nd = (m_cyc / SCAN_DIV) % DIGITS;
        step();
        chk("latch_at_tick", {25'd0, seg}, {25'd0, new_tab[nd]});

        // en gating mid-digit.
        for (int c = 0; c < 8 && (m_cyc % SCAN_DIV) != 1; c++) step();
        a0 = an;
        en = 1'b0;
        repeat (10) step();
        en  = 1'b1;
        cnt = 0;
        step();
        cnt++;
        chk("resume_an", {28'd0, an}, {28'd0, a0});
        while (!scan_tick && cnt < 10) begin
            step();
            cnt++;
        end
        chk("resume_remaining", cnt, 3);

        // Randomized traffic against the reference.
        for (int i = 0; i < 1500; i++) begin
            en     = ($urandom_range(0, 9) != 0);
            latch  = ($urandom_range(0, 9) == 0);
            bcd_in = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom());
            dp_in  = 4'($urandom_range(0, 15));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
